// File: rtl/rule_unpacker_256_16.sv
// rule_unpacker_256_16: splits 256-bit rule beats into a packet-framed stream of 16-bit rule IDs, rev 1.0
// Optional RULE_UNPACKER_STATS_EN adds saturating rule/packet counters (stat_rules, stat_pkts).
`default_nettype none

module rule_unpacker_256_16 #(
   parameter int RULE_W = 16,
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_rule_sop,
   input  logic              in_rule_eop,
   input  logic [4:0]        in_rule_empty,
   input  logic              in_rule_valid,
   input  logic [DATA_W-1:0] in_rule_data,
   output logic              in_rule_ready,
   output logic              out_rule_valid,
   output logic [RULE_W-1:0] out_rule_data,
   output logic              out_rule_sop,
   output logic              out_rule_eop,
`ifdef RULE_UNPACKER_STATS_EN
   output logic [31:0]       stat_rules,
   output logic [31:0]       stat_pkts,
`endif
   input  logic              out_rule_ready
);

   localparam int SLOTS = DATA_W / RULE_W;
   localparam int IDX_W = $clog2(SLOTS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_TERM  = 2'd2
   } state_t;

   state_t              state_q;
   logic [SLOTS-1:0]    pending_q;
   logic [DATA_W-1:0]   beat_q;
   logic                term_q;
   logic                first_q;
   logic                out_valid_q;
   logic [RULE_W-1:0]   out_data_q;
   logic                out_sop_q;
   logic                out_eop_q;

   logic [SLOTS-1:0]    w_in_mask;
   logic [SLOTS-1:0]    w_src_mask;
   logic [DATA_W-1:0]   w_src_data;
   logic [IDX_W-1:0]    w_idx;
   logic [SLOTS-1:0]    w_rem;
   logic [RULE_W-1:0]   w_slot;
   logic                w_out_free;
   logic                w_last_one;
   logic                w_accept;
   logic                w_unused;

   assign w_unused = ^{in_rule_sop, in_rule_empty};

   for (genvar g = 0; g < SLOTS; g++) begin : g_mask
      assign w_in_mask[g] = |in_rule_data[g*RULE_W +: RULE_W];
   end

   // In IDLE the incoming beat is drained directly so its first rule appears one cycle after accept.
   assign w_src_mask = (state_q == S_IDLE) ? w_in_mask    : pending_q;
   assign w_src_data = (state_q == S_IDLE) ? in_rule_data : beat_q;

   always_comb begin
      w_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (w_src_mask[i]) w_idx = i[IDX_W-1:0];
      end
   end

   assign w_rem      = w_src_mask & ~(SLOTS'(1) << w_idx);
   assign w_slot     = w_src_data[int'(w_idx)*RULE_W +: RULE_W];
   assign w_out_free = !out_valid_q || out_rule_ready;
   assign w_last_one = (pending_q != '0) && ((pending_q & (pending_q - SLOTS'(1))) == '0);

   assign in_rule_ready = rst_n &&
                          ((state_q == S_IDLE) ||
                           ((state_q == S_DRAIN) && w_last_one && !term_q && w_out_free));
   assign w_accept = in_rule_valid && in_rule_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pending_q   <= '0;
         beat_q      <= '0;
         term_q      <= 1'b0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end else begin
         if (out_valid_q && out_rule_ready) out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  beat_q <= in_rule_data;
                  term_q <= in_rule_eop;
                  if (w_in_mask != '0) begin
                     if (w_out_free) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= w_slot;
                        out_sop_q   <= first_q;
                        out_eop_q   <= 1'b0;
                        first_q     <= 1'b0;
                        pending_q   <= w_rem;
                        if (w_rem != '0)      state_q <= S_DRAIN;
                        else if (in_rule_eop) state_q <= S_TERM;
                        else                  state_q <= S_IDLE;
                     end else begin
                        pending_q <= w_in_mask;
                        state_q   <= S_DRAIN;
                     end
                  end else if (in_rule_eop) begin
                     pending_q <= '0;
                     state_q   <= S_TERM;
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_free) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= w_slot;
                  out_sop_q   <= first_q;
                  out_eop_q   <= 1'b0;
                  first_q     <= 1'b0;
                  pending_q   <= w_rem;
                  if (w_rem == '0) begin
                     if (term_q) begin
                        state_q <= S_TERM;
                     end else if (w_accept) begin
                        // Back-to-back beat: latch it now so its rules follow without a bubble.
                        beat_q    <= in_rule_data;
                        term_q    <= in_rule_eop;
                        pending_q <= w_in_mask;
                        if (w_in_mask != '0) state_q <= S_DRAIN;
                        else if (in_rule_eop) state_q <= S_TERM;
                        else                  state_q <= S_IDLE;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            S_TERM: begin
               if (w_out_free) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= '0;
                  out_sop_q   <= first_q;
                  out_eop_q   <= 1'b1;
                  first_q     <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_rule_valid = out_valid_q;
   assign out_rule_data  = out_data_q;
   assign out_rule_sop   = out_sop_q;
   assign out_rule_eop   = out_eop_q;

`ifdef RULE_UNPACKER_STATS_EN
   logic [31:0] stat_rules_q;
   logic [31:0] stat_pkts_q;
   logic        w_out_take;

   assign w_out_take = out_valid_q && out_rule_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rules_q <= '0;
         stat_pkts_q  <= '0;
      end else if (w_out_take) begin
         if (!out_eop_q && (stat_rules_q != 32'hFFFF_FFFF)) stat_rules_q <= stat_rules_q + 32'd1;
         if (out_eop_q && (stat_pkts_q != 32'hFFFF_FFFF))   stat_pkts_q  <= stat_pkts_q + 32'd1;
      end
   end

   assign stat_rules = stat_rules_q;
   assign stat_pkts  = stat_pkts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rule_unpacker_256_16.sv
// tb_rule_unpacker_256_16: directed self-checking bench for rule_unpacker_256_16.
`default_nettype none

module tb_rule_unpacker_256_16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_rule_sop;
   logic         in_rule_eop;
   logic [4:0]   in_rule_empty;
   logic         in_rule_valid;
   logic [255:0] in_rule_data;
   logic         in_rule_ready;
   logic         out_rule_valid;
   logic [15:0]  out_rule_data;
   logic         out_rule_sop;
   logic         out_rule_eop;
   logic         out_rule_ready;
`ifdef RULE_UNPACKER_STATS_EN
   logic [31:0]  stat_rules;
   logic [31:0]  stat_pkts;
`endif

   int checks = 0;
   int errors = 0;

   rule_unpacker_256_16 dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_rule_sop    (in_rule_sop),
      .in_rule_eop    (in_rule_eop),
      .in_rule_empty  (in_rule_empty),
      .in_rule_valid  (in_rule_valid),
      .in_rule_data   (in_rule_data),
      .in_rule_ready  (in_rule_ready),
      .out_rule_valid (out_rule_valid),
      .out_rule_data  (out_rule_data),
      .out_rule_sop   (out_rule_sop),
      .out_rule_eop   (out_rule_eop),
`ifdef RULE_UNPACKER_STATS_EN
      .stat_rules     (stat_rules),
      .stat_pkts      (stat_pkts),
`endif
      .out_rule_ready (out_rule_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packs valid/sop/eop/data so one comparison covers the whole output word.
   task automatic chk_word(input string tag, input logic [15:0] d, input logic s, input logic e);
      chk(tag, {13'b0, out_rule_valid, out_rule_sop, out_rule_eop, out_rule_data},
               {13'b0, 1'b1, s, e, d});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] b;
      logic [255:0] b2;

      rst_n          = 1'b0;
      in_rule_sop    = 1'b0;
      in_rule_eop    = 1'b0;
      in_rule_empty  = 5'd0;
      in_rule_valid  = 1'b0;
      in_rule_data   = '0;
      out_rule_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_out", {12'b0, out_rule_valid, out_rule_sop, out_rule_eop, in_rule_ready, out_rule_data}, 32'd0);
`ifdef RULE_UNPACKER_STATS_EN
      chk("reset_stat_rules", stat_rules, 32'd0);
      chk("reset_stat_pkts", stat_pkts, 32'd0);
`endif
      rst_n = 1'b1;
      #1;
      chk("idle_ready", {31'b0, in_rule_ready}, 32'd1);

      // Slots 0/5/15 then an empty eop beat.
      @(negedge clk);
      b = '0;
      b[0*16 +: 16]  = 16'h0011;
      b[5*16 +: 16]  = 16'h0022;
      b[15*16 +: 16] = 16'h0033;
      in_rule_data  = b;
      in_rule_valid = 1'b1;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t1_w0", 16'h0011, 1'b1, 1'b0);
      chk("t1_ready_busy", {31'b0, in_rule_ready}, 32'd0);
      in_rule_data = '0;
      in_rule_eop  = 1'b1;
      step();
      chk_word("t1_w1", 16'h0022, 1'b0, 1'b0);
      chk("t1_ready_last", {31'b0, in_rule_ready}, 32'd1);
      step();
      chk_word("t1_w2", 16'h0033, 1'b0, 1'b0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t1_marker", 16'h0000, 1'b0, 1'b1);
      step();
      chk("t1_idle", {31'b0, out_rule_valid}, 32'd0);
`ifdef RULE_UNPACKER_STATS_EN
      chk("t1_stat_rules", stat_rules, 32'd3);
      chk("t1_stat_pkts", stat_pkts, 32'd1);
`endif

      // Lone empty eop beat: one sop+eop marker.
      in_rule_data  = '0;
      in_rule_eop   = 1'b1;
      in_rule_valid = 1'b1;
      step();
      chk("t2_no_word_yet", {31'b0, out_rule_valid}, 32'd0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t2_marker", 16'h0000, 1'b1, 1'b1);
      step();
      chk("t2_idle", {31'b0, out_rule_valid}, 32'd0);

      // Two full beats (IDs 1..32) then empty eop: 33 consecutive words.
      b  = '0;
      b2 = '0;
      for (int i = 0; i < 16; i++) begin
         b[i*16 +: 16]  = 16'(i + 1);
         b2[i*16 +: 16] = 16'(i + 17);
      end
      in_rule_data  = b;
      in_rule_valid = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         step();
         if (k < 32) chk_word($sformatf("t3_w%0d", k), 16'(k + 1), (k == 0), 1'b0);
         else        chk_word("t3_marker", 16'h0000, 1'b0, 1'b1);
         if (k == 0) in_rule_data = b2;
         if (k == 13) chk("t3_ready_slot14", {31'b0, in_rule_ready}, 32'd0);
         if (k == 14) chk("t3_ready_slot15", {31'b0, in_rule_ready}, 32'd1);
         if (k == 15) begin
            in_rule_data = '0;
            in_rule_eop  = 1'b1;
         end
         if (k == 30) chk("t3_ready_b2_last", {31'b0, in_rule_ready}, 32'd1);
         if (k == 31) begin
            in_rule_valid = 1'b0;
            in_rule_eop   = 1'b0;
         end
      end
      step();
      chk("t3_idle", {31'b0, out_rule_valid}, 32'd0);

      // Backpressure toggling during a 3-rule eop beat.
      b = '0;
      b[1*16 +: 16] = 16'h0101;
      b[2*16 +: 16] = 16'h0202;
      b[3*16 +: 16] = 16'h0303;
      in_rule_data   = b;
      in_rule_eop    = 1'b1;
      in_rule_valid  = 1'b1;
      out_rule_ready = 1'b0;
      step();
      chk_word("t4_w0", 16'h0101, 1'b1, 1'b0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t4_w0_hold", 16'h0101, 1'b1, 1'b0);
      out_rule_ready = 1'b1;
      step();
      chk_word("t4_w1", 16'h0202, 1'b0, 1'b0);
      out_rule_ready = 1'b0;
      step();
      chk_word("t4_w1_hold", 16'h0202, 1'b0, 1'b0);
      out_rule_ready = 1'b1;
      step();
      chk_word("t4_w2", 16'h0303, 1'b0, 1'b0);
      out_rule_ready = 1'b0;
      step();
      chk_word("t4_w2_hold", 16'h0303, 1'b0, 1'b0);
      out_rule_ready = 1'b1;
      step();
      chk_word("t4_marker", 16'h0000, 1'b0, 1'b1);
      out_rule_ready = 1'b0;
      step();
      chk_word("t4_marker_hold", 16'h0000, 1'b0, 1'b1);
      out_rule_ready = 1'b1;
      step();
      chk("t4_idle", {31'b0, out_rule_valid}, 32'd0);

      // Non-eop empty beat inside a packet is dropped silently.
      b = '0;
      b[3*16 +: 16] = 16'h0AAA;
      in_rule_data  = b;
      in_rule_valid = 1'b1;
      step();
      chk_word("t5_w0", 16'h0AAA, 1'b1, 1'b0);
      in_rule_data = '0;
      step();
      chk("t5_gap", {31'b0, out_rule_valid}, 32'd0);
      b = '0;
      b[7*16 +: 16] = 16'h0BBB;
      in_rule_data = b;
      in_rule_eop  = 1'b1;
      step();
      chk_word("t5_w1", 16'h0BBB, 1'b0, 1'b0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t5_marker", 16'h0000, 1'b0, 1'b1);
      step();

      // Reset after 2 of 4 rules.
      b = '0;
      for (int i = 0; i < 4; i++) b[i*16 +: 16] = 16'h0F01 + 16'(i);
      in_rule_data  = b;
      in_rule_eop   = 1'b1;
      in_rule_valid = 1'b1;
      step();
      chk_word("t6_w0", 16'h0F01, 1'b1, 1'b0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t6_w1", 16'h0F02, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_reset_out", {12'b0, out_rule_valid, out_rule_sop, out_rule_eop, in_rule_ready, out_rule_data}, 32'd0);
`ifdef RULE_UNPACKER_STATS_EN
      chk("t6_stat_rules", stat_rules, 32'd0);
      chk("t6_stat_pkts", stat_pkts, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t6_discarded", {31'b0, out_rule_valid}, 32'd0);
      b = '0;
      b[0*16 +: 16] = 16'h0123;
      in_rule_data  = b;
      in_rule_eop   = 1'b1;
      in_rule_valid = 1'b1;
      step();
      chk_word("t6_new_w0", 16'h0123, 1'b1, 1'b0);
      in_rule_valid = 1'b0;
      in_rule_eop   = 1'b0;
      step();
      chk_word("t6_new_marker", 16'h0000, 1'b0, 1'b1);
      step();
      chk("t6_idle", {31'b0, out_rule_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
